// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encoding and default sizes for the scanning N-to-1 selector
package mux_pkg;
    typedef enum logic [1:0] {
        MANUAL = 2'b00,
        SCAN   = 2'b01,
        HOLD   = 2'b10,
        RSVD   = 2'b11
    } mode_e;
    localparam int WIDTH_DEF   = 4;
    localparam int N_DEF       = 4;
    localparam int DWELL_W_DEF = 8;
endpackage

// File: rtl/mux_next_sel.sv
// mux_next_sel: next enabled channel after cur_sel, searching cyclically upward.
// Ports: cur_sel (current index), en_mask (channel enables) -> nxt (next enabled
// index, cur_sel itself if it is the only one), wrap_flag (nxt <= cur_sel),
// any_en (at least one channel enabled).
module mux_next_sel #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [SEL_W-1:0] cur_sel,
    input  logic [N-1:0]     en_mask,
    output logic [SEL_W-1:0] nxt,
    output logic             wrap_flag,
    output logic             any_en
);
    always_comb begin
        nxt = cur_sel;
        // walk from the farthest offset down so the nearest enabled channel wins
        for (int k = N; k >= 1; k--) begin
            if (en_mask[(int'(cur_sel) + k) % N]) nxt = SEL_W'((int'(cur_sel) + k) % N);
        end
        wrap_flag = nxt <= cur_sel;
        any_en    = |en_mask;
    end
endmodule

// File: rtl/mux_nto1_scan.sv
// mux_nto1_scan: registered N-to-1 selector with manual, round-robin scan and hold modes.
// Ports: clk/rst (sync active-high), d (packed channels), sel (manual select),
// mode (00 manual, 01 scan, 10/11 hold), en_mask (scan enables), dwell (extra
// cycles per channel) -> y (selected data), y_valid, cur_sel (channel of y),
// wrap (pulse on a scan advance that wraps).
module mux_nto1_scan
    import mux_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int N       = N_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int SEL_W   = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   d,
    input  logic [SEL_W-1:0]     sel,
    input  logic [1:0]           mode,
    input  logic [N-1:0]         en_mask,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [WIDTH-1:0]     y,
    output logic                 y_valid,
    output logic [SEL_W-1:0]     cur_sel,
    output logic                 wrap
);
    mode_e              r_st, w_st;
    logic [DWELL_W-1:0] r_cnt, w_cnt;
    logic [WIDTH-1:0]   r_y, w_y;
    logic               r_valid, w_valid;
    logic [SEL_W-1:0]   r_sel, w_sel;
    logic               r_wrap, w_wrap;
    logic [WIDTH-1:0]   w_ch [N];
    logic [SEL_W-1:0]   w_nxt;
    logic               w_wrap_flag, w_any;
    logic               w_sel_ok;

    for (genvar i = 0; i < N; i++) begin : g_ch
        assign w_ch[i] = d[i*WIDTH +: WIDTH];
    end

    mux_next_sel #(.N(N), .SEL_W(SEL_W)) u_next (
        .cur_sel   (r_sel),
        .en_mask   (en_mask),
        .nxt       (w_nxt),
        .wrap_flag (w_wrap_flag),
        .any_en    (w_any)
    );

    // sel can exceed N-1 only when N is not a power of two
    assign w_sel_ok = int'(sel) < N;

    always_comb begin
        w_st    = (mode_e'(mode) == RSVD) ? HOLD : mode_e'(mode);
        w_y     = r_y;
        w_valid = r_valid;
        w_sel   = r_sel;
        w_cnt   = r_cnt;
        w_wrap  = 1'b0;
        case (w_st)
            MANUAL: begin
                w_cnt   = '0;
                w_sel   = w_sel_ok ? sel : r_sel;
                w_y     = w_sel_ok ? w_ch[sel] : '0;
                w_valid = w_sel_ok;
            end
            SCAN: begin
                if (r_st != SCAN) begin
                    // entry restarts the dwell on the channel already shown
                    w_cnt   = '0;
                    w_y     = w_ch[r_sel];
                    w_valid = en_mask[r_sel];
                end else if (!w_any) begin
                    w_y     = '0;
                    w_valid = 1'b0;
                end else if (en_mask[r_sel] && r_cnt < dwell) begin
                    w_cnt   = r_cnt + 1'b1;
                    w_y     = w_ch[r_sel];
                    w_valid = 1'b1;
                end else begin
                    w_sel   = w_nxt;
                    w_y     = w_ch[w_nxt];
                    w_valid = 1'b1;
                    w_cnt   = '0;
                    w_wrap  = w_wrap_flag;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st    <= HOLD;
            r_cnt   <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_sel   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_st    <= w_st;
            r_cnt   <= w_cnt;
            r_y     <= w_y;
            r_valid <= w_valid;
            r_sel   <= w_sel;
            r_wrap  <= w_wrap;
        end
    end

    assign y       = r_y;
    assign y_valid = r_valid;
    assign cur_sel = r_sel;
    assign wrap    = r_wrap;
endmodule

// File: tb/tb_mux_nto1_scan.sv
// tb_mux_nto1_scan: directed bench with a cycle model and literal checkpoints
module tb_mux_nto1_scan;
    import mux_pkg::*;
    localparam int N = 4;
    localparam logic [15:0] BASE = 16'h63BF;

    logic        clk = 0;
    logic        rst;
    logic [15:0] d;
    logic [1:0]  sel;
    logic [1:0]  mode;
    logic [3:0]  en_mask;
    logic [7:0]  dwell;
    logic [3:0]  y;
    logic        y_valid;
    logic [1:0]  cur_sel;
    logic        wrap;

    int checks = 0;
    int failures = 0;

    mux_nto1_scan #(.WIDTH(4), .N(4), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .d(d), .sel(sel), .mode(mode), .en_mask(en_mask),
        .dwell(dwell), .y(y), .y_valid(y_valid), .cur_sel(cur_sel), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ch(int i);
        return d[i*4 +: 4];
    endfunction

    logic [3:0] m_y;
    logic       m_v;
    int         m_sel;
    int         m_cnt;
    logic       m_wrap;
    int         m_prev;
    bit         m_live = 0;

    always @(posedge clk) begin
        int md;
        int nx;
        if (rst) begin
            m_y = 0; m_v = 0; m_sel = 0; m_cnt = 0; m_wrap = 0; m_prev = 2; m_live = 1;
        end else begin
            md = (mode == 2'd3) ? 2 : int'(mode);
            m_wrap = 0;
            if (md == 0) begin
                m_cnt = 0; m_sel = sel; m_y = ch(sel); m_v = 1;
            end else if (md == 1) begin
                if (m_prev != 1) begin
                    m_cnt = 0; m_y = ch(m_sel); m_v = en_mask[m_sel];
                end else if (en_mask == 0) begin
                    m_y = 0; m_v = 0;
                end else if (en_mask[m_sel] && m_cnt < int'(dwell)) begin
                    m_cnt = m_cnt + 1; m_y = ch(m_sel); m_v = 1;
                end else begin
                    nx = -1;
                    for (int i = m_sel + 1; i < N; i++) if (nx < 0 && en_mask[i]) nx = i;
                    for (int i = 0; i < N; i++) if (nx < 0 && en_mask[i]) nx = i;
                    m_wrap = (nx <= m_sel);
                    m_sel = nx; m_y = ch(nx); m_v = 1; m_cnt = 0;
                end
            end
            m_prev = md;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            checks++;
            if ({y, y_valid, cur_sel, wrap} !== {m_y, m_v, m_sel[1:0], m_wrap}) begin
                failures++;
                $display("FAIL model t=%0t got y=%h v=%b sel=%0d wrap=%b want y=%h v=%b sel=%0d wrap=%b",
                         $time, y, y_valid, cur_sel, wrap, m_y, m_v, m_sel, m_wrap);
            end
        end
    end

    task automatic chk(string nm, logic [3:0] ey, logic ev, logic [1:0] es, logic ew);
        checks++;
        if ({y, y_valid, cur_sel, wrap} !== {ey, ev, es, ew}) begin
            failures++;
            $display("FAIL %s got y=%h v=%b sel=%0d wrap=%b want y=%h v=%b sel=%0d wrap=%b",
                     nm, y, y_valid, cur_sel, wrap, ey, ev, es, ew);
        end
    endtask

    int         seq3 [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    logic [3:0] dv [4] = '{4'hF, 4'hB, 4'h3, 4'h6};

    initial begin
        d = BASE; rst = 1; mode = MANUAL; sel = 2; en_mask = 4'hF; dwell = 0;
        repeat (2) @(negedge clk);
        chk("reset", 4'h0, 0, 0, 0);

        rst = 0; sel = 1;
        @(negedge clk); chk("man_sel1", 4'hB, 1, 1, 0);
        sel = 3;
        @(negedge clk); chk("man_sel3", 4'h6, 1, 3, 0);
        d[15:12] = 4'h9;
        @(negedge clk); chk("man_live", 4'h9, 1, 3, 0);
        d = BASE; sel = 0;
        @(negedge clk); chk("man_sel0", 4'hF, 1, 0, 0);

        mode = SCAN; dwell = 2; en_mask = 4'hF;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk($sformatf("scan_dwell2_%0d", i), dv[seq3[i]], 1, 2'(seq3[i]), i == 12);
        end

        mode = MANUAL; sel = 0;
        @(negedge clk);
        mode = SCAN; dwell = 0; en_mask = 4'b1010;
        @(negedge clk); chk("sparse_entry", 4'hF, 0, 0, 0);
        @(negedge clk); chk("sparse_1", 4'hB, 1, 1, 0);
        @(negedge clk); chk("sparse_3", 4'h6, 1, 3, 0);
        @(negedge clk); chk("sparse_wrap1", 4'hB, 1, 1, 1);
        @(negedge clk); chk("sparse_3b", 4'h6, 1, 3, 0);
        @(negedge clk); chk("sparse_wrap2", 4'hB, 1, 1, 1);

        mode = HOLD;
        for (int i = 0; i < 5; i++) begin
            d = 16'($urandom);
            @(negedge clk); chk($sformatf("hold_%0d", i), 4'hB, 1, 1, 0);
        end
        d = BASE; mode = RSVD;
        @(negedge clk); chk("hold_rsvd", 4'hB, 1, 1, 0);
        mode = SCAN; dwell = 1;
        @(negedge clk); chk("resume_entry", 4'hB, 1, 1, 0);
        @(negedge clk); chk("resume_dwell", 4'hB, 1, 1, 0);
        @(negedge clk); chk("resume_adv", 4'h6, 1, 3, 0);
        @(negedge clk); chk("resume_dwell3", 4'h6, 1, 3, 0);
        @(negedge clk); chk("resume_wrap", 4'hB, 1, 1, 1);

        en_mask = 4'b0000;
        @(negedge clk); chk("none_en_a", 4'h0, 0, 1, 0);
        @(negedge clk); chk("none_en_b", 4'h0, 0, 1, 0);
        en_mask = 4'b0100;
        @(negedge clk); chk("single_pick", 4'h3, 1, 2, 0);
        @(negedge clk); chk("single_dwell", 4'h3, 1, 2, 0);
        @(negedge clk); chk("single_wrap", 4'h3, 1, 2, 1);

        en_mask = 4'hF; dwell = 5;
        repeat (4) @(negedge clk);
        dwell = 1;
        @(negedge clk); chk("dwell_lowered", 4'h6, 1, 3, 0);

        dwell = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk); chk("reset_mid_scan", 4'h0, 0, 0, 0);
        rst = 0;
        @(negedge clk); chk("post_reset_entry", 4'hF, 1, 0, 0);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) en_mask = 4'($urandom);
            if ($urandom_range(0, 3) == 0) dwell = 8'($urandom_range(0, 3));
            sel = 2'($urandom);
            d = 16'($urandom);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
